dose_scheduler: RTL and testbench

Dose scheduler for the dispenser. Holds a table of programmed dose times and watches the running time of day from the clock datapath. When a programmed time is reached, it sequences the dispensing motor: one compartment at a time, with a request/done handshake and a timeout. It sits between the clock block (time source) and the motor driver (shared actuator), arbitrating all slots onto the single motor.

---
 rtl/dispenser_pkg.sv | 17 +
 rtl/dose_slot.sv | 57 +++++
 rtl/dose_scheduler.sv | 134 +++++++++++++
 tb/tb_dose_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispenser_pkg.sv
// Shared widths, time limits and scheduler state encoding for the dispenser blocks.
package dispenser_pkg;

  localparam int HOURS_W   = 5;
  localparam int MIN_W     = 6;
  localparam int SEC_W     = 6;
  localparam int MAX_HOURS = 23;
  localparam int MAX_MIN   = 59;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_REQ   = 2'd1,
    SCHED_ALARM = 2'd2,
    SCHED_FAULT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dose_slot.sv
// One dose slot: programmed time and enable, match against the current time, and its pending flag.
module dose_slot
  import dispenser_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               trigger,
  input  logic [HOURS_W-1:0] hours,
  input  logic [MIN_W-1:0]   minutes,
  input  logic               cfg_sel,
  input  logic [HOURS_W-1:0] cfg_hours,
  input  logic [MIN_W-1:0]   cfg_minutes,
  input  logic               cfg_enable,
  input  logic               serving,
  input  logic               done_clear,
  output logic               pending
);

  logic               enable_reg;
  logic [HOURS_W-1:0] hours_reg;
  logic [MIN_W-1:0]   minutes_reg;
  logic               pending_reg;
  logic               pending_next;
  logic               hit;
  logic               cancel;

  assign hit    = trigger && enable_reg && (hours == hours_reg) && (minutes == minutes_reg);
  assign cancel = done_clear || (cfg_sel && !cfg_enable && !serving);

  // A new match beats a simultaneous cancel.
  always_comb begin
    pending_next = pending_reg;
    if (cancel)
      pending_next = 1'b0;
    if (hit)
      pending_next = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_reg  <= 1'b0;
      hours_reg   <= '0;
      minutes_reg <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (cfg_sel) begin
        enable_reg  <= cfg_enable;
        hours_reg   <= cfg_hours;
        minutes_reg <= cfg_minutes;
      end
      pending_reg <= pending_next;
    end
  end

  assign pending = pending_reg;

endmodule

// File: rtl/dose_scheduler.sv
// Dose scheduler: per-slot time triggers arbitrated onto one motor with done/timeout handshake.
// Define DOSE_ACK_EN to add the post-dispense ALARM state gated by the ack input.
module dose_scheduler
  import dispenser_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [HOURS_W-1:0]           hours,
  input  logic [MIN_W-1:0]             minutes,
  input  logic [SEC_W-1:0]             seconds,
  input  logic                         time_valid,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic [HOURS_W-1:0]           cfg_hours,
  input  logic [MIN_W-1:0]             cfg_minutes,
  input  logic                         cfg_enable,
  output logic                         motor_req,
  output logic [$clog2(NUM_SLOTS)-1:0] motor_compartment,
  input  logic                         motor_done,
  output logic [NUM_SLOTS-1:0]         pending,
  output logic                         fault,
  output logic                         alarm,
  input  logic                         ack
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t      state_reg;
  logic [SLOT_W-1:0] grant_reg;
  logic [SLOT_W-1:0] lowest_idx;
  logic [CNT_W-1:0]  count_reg;
  logic [SEC_W-1:0]  prev_seconds_reg;
  logic              motor_req_reg;
  logic              fault_reg;
  logic              trigger;

  // One trigger per minute rollover; a stalled or held clock never re-triggers.
  assign trigger = time_valid && (seconds == '0) && (prev_seconds_reg != '0);

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    dose_slot u_slot (
      .clock       (clock),
      .reset       (reset),
      .trigger     (trigger),
      .hours       (hours),
      .minutes     (minutes),
      .cfg_sel     (cfg_we && (cfg_slot == SLOT_W'(gi))),
      .cfg_hours   (cfg_hours),
      .cfg_minutes (cfg_minutes),
      .cfg_enable  (cfg_enable),
      .serving     ((state_reg == SCHED_REQ) && (grant_reg == SLOT_W'(gi))),
      .done_clear  ((state_reg == SCHED_REQ) && motor_done && (grant_reg == SLOT_W'(gi))),
      .pending     (pending[gi])
    );
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (pending[i])
        lowest_idx = SLOT_W'(i);
  end

`ifdef DOSE_ACK_EN
  logic alarm_reg;
  assign alarm = alarm_reg;
`else
  logic unused_ack;
  assign unused_ack = ack;
  assign alarm      = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= SCHED_IDLE;
      grant_reg        <= '0;
      count_reg        <= '0;
      prev_seconds_reg <= '0;
      motor_req_reg    <= 1'b0;
      fault_reg        <= 1'b0;
`ifdef DOSE_ACK_EN
      alarm_reg        <= 1'b0;
`endif
    end else begin
      prev_seconds_reg <= seconds;
      case (state_reg)
        SCHED_IDLE: begin
          if ((pending != '0) && !fault_reg) begin
            grant_reg     <= lowest_idx;
            count_reg     <= '0;
            motor_req_reg <= 1'b1;
            state_reg     <= SCHED_REQ;
          end
        end
        SCHED_REQ: begin
          if (motor_done) begin
            motor_req_reg <= 1'b0;
`ifdef DOSE_ACK_EN
            alarm_reg     <= 1'b1;
            state_reg     <= SCHED_ALARM;
`else
            state_reg     <= SCHED_IDLE;
`endif
          end else if (count_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            motor_req_reg <= 1'b0;
            fault_reg     <= 1'b1;
            state_reg     <= SCHED_FAULT;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end
`ifdef DOSE_ACK_EN
        SCHED_ALARM: begin
          if (ack) begin
            alarm_reg <= 1'b0;
            state_reg <= SCHED_IDLE;
          end
        end
`endif
        SCHED_FAULT: state_reg <= SCHED_FAULT;
        default:     state_reg <= SCHED_IDLE;
      endcase
    end
  end

  assign motor_req         = motor_req_reg;
  assign motor_compartment = grant_reg;
  assign fault             = fault_reg;

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler; grants are checked against a queue of expected compartments.
module tb_dose_scheduler;
  import dispenser_pkg::*;

  localparam int NUM_SLOTS = 4;
  localparam int TIMEOUT   = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [HOURS_W-1:0]   hours = '0;
  logic [MIN_W-1:0]     minutes = '0;
  logic [SEC_W-1:0]     seconds = '0;
  logic                 time_valid = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [1:0]           cfg_slot = '0;
  logic [HOURS_W-1:0]   cfg_hours = '0;
  logic [MIN_W-1:0]     cfg_minutes = '0;
  logic                 cfg_enable = 1'b0;
  logic                 motor_req;
  logic [1:0]           motor_compartment;
  logic                 motor_done = 1'b0;
  logic [NUM_SLOTS-1:0] pending;
  logic                 fault;
  logic                 alarm;
  logic                 ack = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] sb_exp;
  logic       prev_req = 1'b0;

  dose_scheduler #(.NUM_SLOTS(NUM_SLOTS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock             (clock),
    .reset             (reset),
    .hours             (hours),
    .minutes           (minutes),
    .seconds           (seconds),
    .time_valid        (time_valid),
    .cfg_we            (cfg_we),
    .cfg_slot          (cfg_slot),
    .cfg_hours         (cfg_hours),
    .cfg_minutes       (cfg_minutes),
    .cfg_enable        (cfg_enable),
    .motor_req         (motor_req),
    .motor_compartment (motor_compartment),
    .motor_done        (motor_done),
    .pending           (pending),
    .fault             (fault),
    .alarm             (alarm),
    .ack               (ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours   = HOURS_W'(h);
    minutes = MIN_W'(m);
    seconds = SEC_W'(s);
  endtask

  task automatic cfg(input int slot, input int h, input int m, input logic en);
    cfg_we      = 1'b1;
    cfg_slot    = 2'(slot);
    cfg_hours   = HOURS_W'(h);
    cfg_minutes = MIN_W'(m);
    cfg_enable  = en;
    tick();
    cfg_we = 1'b0;
  endtask

  // Completes the current handshake; returns with the FSM entering IDLE at the next edge's start.
  task automatic finish_dispense(input string tag, input logic [3:0] exp_pending);
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    check({tag, "_req_drop"}, motor_req, 1'b0);
    check({tag, "_pending"}, pending, exp_pending);
`ifdef DOSE_ACK_EN
    check({tag, "_alarm_on"}, alarm, 1'b1);
    tick();
    check({tag, "_held_off"}, motor_req, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_alarm_off"}, alarm, 1'b0);
    check({tag, "_idle_req"}, motor_req, 1'b0);
`else
    check({tag, "_alarm_tied"}, alarm, 1'b0);
`endif
  endtask

  // Scoreboard: every rising motor_req must match the next expected compartment.
  always @(negedge clock) begin
    if (motor_req && !prev_req) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_req: observed compartment %0d expected no request", motor_compartment);
      end
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        check("sb_compartment", motor_compartment, sb_exp);
      end
    end
    prev_req = motor_req;
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req", motor_req, 1'b0);
    check("rst_pending", pending, 4'b0000);
    check("rst_fault", fault, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_comp", motor_compartment, 2'd0);
    reset = 1'b0;
    tick();

    // Single slot at 08:30
    cfg(1, 8, 30, 1'b1);
    time_valid = 1'b1;
    set_time(8, 29, 59);
    tick();
    set_time(8, 30, 0);
    exp_q.push_back(2'd1);
    tick();
    check("t1_pending", pending, 4'b0010);
    check("t1_req_not_yet", motor_req, 1'b0);
    seconds = 6'd1;
    tick();
    check("t1_req", motor_req, 1'b1);
    check("t1_comp", motor_compartment, 2'd1);
    repeat (9) tick();
    finish_dispense("t1_done", 4'b0000);

    // Two slots at 12:00, lowest index first
    cfg(0, 12, 0, 1'b1);
    cfg(2, 12, 0, 1'b1);
    set_time(11, 59, 59);
    tick();
    set_time(12, 0, 0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    tick();
    check("t2_pending", pending, 4'b0101);
    seconds = 6'd1;
    tick();
    check("t2_req0", motor_req, 1'b1);
    check("t2_comp0", motor_compartment, 2'd0);
    repeat (3) tick();
    finish_dispense("t2_done0", 4'b0100);
    tick();
    check("t2_req2", motor_req, 1'b1);
    check("t2_comp2", motor_compartment, 2'd2);
    repeat (2) tick();
    finish_dispense("t2_done2", 4'b0000);
    tick();
    check("t2_idle", motor_req, 1'b0);

    // time_valid low suppresses the rollover, raising it later does not replay it
    cfg(0, 7, 0, 1'b1);
    cfg(3, 7, 0, 1'b1);
    time_valid = 1'b0;
    set_time(6, 59, 59);
    tick();
    set_time(7, 0, 0);
    tick();
    tick();
    check("t4_invalid_pending", pending, 4'b0000);
    time_valid = 1'b1;
    tick();
    tick();
    check("t4_valid_pending", pending, 4'b0000);
    check("t4_valid_req", motor_req, 1'b0);

    // Seconds held at 0 for three cycles; disable slot 3 while queued behind slot 0
    cfg(0, 7, 1, 1'b1);
    cfg(3, 7, 1, 1'b1);
    set_time(7, 0, 59);
    tick();
    set_time(7, 1, 0);
    exp_q.push_back(2'd0);
    tick();
    check("t5_pending", pending, 4'b1001);
    cfg(3, 7, 1, 1'b0);
    check("t5_disable", pending, 4'b0001);
    check("t5_req", motor_req, 1'b1);
    check("t5_comp", motor_compartment, 2'd0);
    tick();
    check("t5_no_retrigger", pending, 4'b0001);
    seconds = 6'd1;

    // Asynchronous reset mid-handshake
    reset = 1'b1;
    #1;
    check("t5_rst_req", motor_req, 1'b0);
    check("t5_rst_pending", pending, 4'b0000);
    check("t5_rst_fault", fault, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_after_rst", pending, 4'b0000);

    // Timeout with motor_done held low
    cfg(1, 9, 0, 1'b1);
    cfg(2, 9, 1, 1'b1);
    set_time(8, 59, 59);
    tick();
    set_time(9, 0, 0);
    exp_q.push_back(2'd1);
    tick();
    check("t3_pending", pending, 4'b0010);
    seconds = 6'd1;
    tick();
    check("t3_req", motor_req, 1'b1);
    repeat (TIMEOUT - 1) tick();
    check("t3_fault_early", fault, 1'b0);
    check("t3_req_held", motor_req, 1'b1);
    tick();
    check("t3_fault", fault, 1'b1);
    check("t3_req_drop", motor_req, 1'b0);
    set_time(9, 0, 59);
    tick();
    set_time(9, 1, 0);
    tick();
    check("t3_pending_accum", pending, 4'b0110);
    seconds = 6'd1;
    repeat (3) tick();
    check("t3_no_req", motor_req, 1'b0);
    check("t3_fault_sticky", fault, 1'b1);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
